// File: rtl/zcmt_lsu_port_arbiter_pkg.sv
// Shared definitions for the ZCMT / load-unit port arbiter.
// Contents: a minimal core configuration record (XLEN only), the owner
// encoding stored in the response-order FIFO, the owner FSM state constants
// and the default starvation limit.
package zcmt_lsu_port_arbiter_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd32};

  localparam int unsigned STARVE_LIMIT_DEFAULT = 32'd4;

  // Owner encoding held in the response-order FIFO
  localparam logic OWNER_LSU  = 1'b0;
  localparam logic OWNER_ZCMT = 1'b1;

  // Owner FSM states
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_BUSY_ZCMT = 2'd1;
  localparam logic [1:0] ST_BUSY_LSU  = 2'd2;

  // BUSY state that holds the port for the given owner
  function automatic logic [1:0] busy_state(input logic owner);
    return (owner == OWNER_ZCMT) ? ST_BUSY_ZCMT : ST_BUSY_LSU;
  endfunction

endpackage

// File: rtl/zcmt_lsu_port_arbiter_fifo.sv
// fifo_v3: small synchronous FIFO used to remember which requester owns each
// in-flight request on the shared port.
// Ports: clk_i, rst_ni (async, active-low), flush_i (sync clear),
//        full_o/empty_o status, data_i/push_i write side, data_o/pop_i read side.
// Pushes while full and pops while empty are ignored.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32'd32,
  parameter int unsigned DEPTH      = 32'd8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned AW = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;

  logic [AW-1:0]         rd_ptr_r, wr_ptr_r;
  logic [AW:0]           cnt_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic                  push_s, pop_s;

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 32'd1)) ? {AW{1'b0}} : ptr + AW'(1);
  endfunction

  assign full_o  = (cnt_r == (AW+1)'(DEPTH));
  assign empty_o = (cnt_r == {(AW+1){1'b0}});
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;
  assign data_o  = mem_r[rd_ptr_r];

  // Pointers, occupancy and storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      cnt_r    <= {(AW+1){1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= {DATA_WIDTH{1'b0}};
    end else if (flush_i) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      cnt_r    <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
        2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/zcmt_lsu_port_arbiter_sva.sv
// Protocol checker for zcmt_lsu_port_arbiter.
// Ports: clk_i, rst_i, owner FSM state, both request lines, port_rvalid_i and
// the owner FIFO empty flag.
// A requester must keep its request up while it owns the port. A response
// arriving with nothing outstanding is recorded in a sticky flag and covered,
// so it shows up in coverage without stopping a run that resets mid-flight.
module zcmt_lsu_port_arbiter_sva
  import zcmt_lsu_port_arbiter_pkg::*;
(
  input logic       clk_i,
  input logic       rst_i,
  input logic [1:0] state_i,
  input logic       zcmt_req_i,
  input logic       lsu_req_i,
  input logic       port_rvalid_i,
  input logic       fifo_empty_i
);

  logic spurious_rsp_r;

  // Sticky record of a response with no owner to route it to
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) spurious_rsp_r <= 1'b0;
    else if (port_rvalid_i && fifo_empty_i) spurious_rsp_r <= 1'b1;
    else spurious_rsp_r <= spurious_rsp_r;
  end

  zcmt_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_i == ST_BUSY_ZCMT) |-> zcmt_req_i)
    else $error("zcmt_lsu_port_arbiter: ZCMT dropped req while owning the port");

  lsu_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_i == ST_BUSY_LSU) |-> lsu_req_i)
    else $error("zcmt_lsu_port_arbiter: LSU dropped req while owning the port");

  spurious_rsp_c: cover property (@(posedge clk_i) spurious_rsp_r);

endmodule

// File: rtl/zcmt_lsu_port_arbiter.sv
// zcmt_lsu_port_arbiter: shares one dcache request port between the ZCMT
// jump-table fetcher and the load unit.
// Ports: clk_i / rst_i (async, active-high); zcmt_req/addr in, zcmt_gnt/rvalid/
// rdata out; lsu_req/addr/be in, lsu_gnt/rvalid/rdata out; port_req/addr/be out,
// port_gnt/rvalid/rdata in.
// The winner is driven onto the port in the same cycle it asks; an ungranted
// request keeps the port until granted. Response order is tracked by a 1-bit
// owner FIFO. All outputs are forced low while rst_i is high.
module zcmt_lsu_port_arbiter
  import zcmt_lsu_port_arbiter_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg         = cva6_cfg_empty,
  parameter int unsigned STARVE_LIMIT    = STARVE_LIMIT_DEFAULT,
  parameter int unsigned MAX_OUTSTANDING = 32'd2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          zcmt_req_i,
  input  logic [CVA6Cfg.XLEN-1:0]       zcmt_addr_i,
  output logic                          zcmt_gnt_o,
  output logic                          zcmt_rvalid_o,
  output logic [CVA6Cfg.XLEN-1:0]       zcmt_rdata_o,
  input  logic                          lsu_req_i,
  input  logic [CVA6Cfg.XLEN-1:0]       lsu_addr_i,
  input  logic [CVA6Cfg.XLEN/8-1:0]     lsu_be_i,
  output logic                          lsu_gnt_o,
  output logic                          lsu_rvalid_o,
  output logic [CVA6Cfg.XLEN-1:0]       lsu_rdata_o,
  output logic                          port_req_o,
  output logic [CVA6Cfg.XLEN-1:0]       port_addr_o,
  output logic [CVA6Cfg.XLEN/8-1:0]     port_be_o,
  input  logic                          port_gnt_i,
  input  logic                          port_rvalid_i,
  input  logic [CVA6Cfg.XLEN-1:0]       port_rdata_i
);

  localparam int unsigned XLEN = CVA6Cfg.XLEN;
  localparam int unsigned BEW  = XLEN / 32'd8;
  localparam int unsigned CW   = $clog2(STARVE_LIMIT + 32'd1);

  logic [1:0]    state_r, state_nxt_s;
  logic [CW-1:0] starve_r;
  logic          fifo_full_s, fifo_empty_s, head_owner_s;
  logic          req_s, sel_zcmt_s, issue_s, grant_s, pop_s;

  // Owner selection and next-state; BUSY states skip the full check because
  // no push can happen while a request is waiting for its grant
  always_comb begin
    req_s       = 1'b0;
    sel_zcmt_s  = OWNER_LSU;
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_full_s && (zcmt_req_i || lsu_req_i)) begin
          req_s       = 1'b1;
          sel_zcmt_s  = zcmt_req_i && (!lsu_req_i || (starve_r == CW'(STARVE_LIMIT)));
          state_nxt_s = port_gnt_i ? ST_IDLE : busy_state(sel_zcmt_s);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY_ZCMT: begin
        sel_zcmt_s = OWNER_ZCMT;
        if (zcmt_req_i) begin
          req_s       = 1'b1;
          state_nxt_s = port_gnt_i ? ST_IDLE : ST_BUSY_ZCMT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY_LSU: begin
        sel_zcmt_s = OWNER_LSU;
        if (lsu_req_i) begin
          req_s       = 1'b1;
          state_nxt_s = port_gnt_i ? ST_IDLE : ST_BUSY_LSU;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign issue_s = req_s && !rst_i;
  assign grant_s = issue_s && port_gnt_i;
  assign pop_s   = port_rvalid_i && !fifo_empty_s && !rst_i;

  assign port_req_o  = issue_s;
  assign port_addr_o = !issue_s ? {XLEN{1'b0}} : (sel_zcmt_s ? zcmt_addr_i : lsu_addr_i);
  assign port_be_o   = !issue_s ? {BEW{1'b0}}  : (sel_zcmt_s ? {BEW{1'b1}} : lsu_be_i);
  assign zcmt_gnt_o  = grant_s && (sel_zcmt_s == OWNER_ZCMT);
  assign lsu_gnt_o   = grant_s && (sel_zcmt_s == OWNER_LSU);

  assign zcmt_rvalid_o = pop_s && (head_owner_s == OWNER_ZCMT);
  assign lsu_rvalid_o  = pop_s && (head_owner_s == OWNER_LSU);
  assign zcmt_rdata_o  = rst_i ? {XLEN{1'b0}} : port_rdata_i;
  assign lsu_rdata_o   = rst_i ? {XLEN{1'b0}} : port_rdata_i;

  // Owner FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_r <= ST_IDLE;
    else state_r <= state_nxt_s;
  end

  // Starvation counter: counts LSU grants that ZCMT sat through
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) starve_r <= {CW{1'b0}};
    else if (!zcmt_req_i || zcmt_gnt_o) starve_r <= {CW{1'b0}};
    else if (lsu_gnt_o && (starve_r != CW'(STARVE_LIMIT))) starve_r <= starve_r + CW'(1);
    else starve_r <= starve_r;
  end

  fifo_v3 #(
    .DATA_WIDTH (32'd1),
    .DEPTH      (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .flush_i (1'b0),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .data_i  (sel_zcmt_s),
    .push_i  (grant_s),
    .data_o  (head_owner_s),
    .pop_i   (pop_s)
  );

  zcmt_lsu_port_arbiter_sva u_sva (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .state_i       (state_r),
    .zcmt_req_i    (zcmt_req_i),
    .lsu_req_i     (lsu_req_i),
    .port_rvalid_i (port_rvalid_i),
    .fifo_empty_i  (fifo_empty_s)
  );

endmodule

// File: tb/tb_zcmt_lsu_port_arbiter.sv
// Directed self-checking bench for zcmt_lsu_port_arbiter (XLEN 32,
// STARVE_LIMIT 4, MAX_OUTSTANDING 2). Inputs change 1 time unit after the
// rising edge; outputs are checked 1 unit later, well before the next edge.
module tb_zcmt_lsu_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        zcmt_req_i;
  logic [31:0] zcmt_addr_i;
  logic        zcmt_gnt_o, zcmt_rvalid_o;
  logic [31:0] zcmt_rdata_o;
  logic        lsu_req_i;
  logic [31:0] lsu_addr_i;
  logic [3:0]  lsu_be_i;
  logic        lsu_gnt_o, lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        port_req_o;
  logic [31:0] port_addr_o;
  logic [3:0]  port_be_o;
  logic        port_gnt_i, port_rvalid_i;
  logic [31:0] port_rdata_i;

  int tests_run    = 0;
  int tests_failed = 0;

  // expected grant owner per cycle of the contention run, bit i = 1 -> ZCMT
  logic [9:0] z_pattern;

  zcmt_lsu_port_arbiter dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .zcmt_req_i    (zcmt_req_i),
    .zcmt_addr_i   (zcmt_addr_i),
    .zcmt_gnt_o    (zcmt_gnt_o),
    .zcmt_rvalid_o (zcmt_rvalid_o),
    .zcmt_rdata_o  (zcmt_rdata_o),
    .lsu_req_i     (lsu_req_i),
    .lsu_addr_i    (lsu_addr_i),
    .lsu_be_i      (lsu_be_i),
    .lsu_gnt_o     (lsu_gnt_o),
    .lsu_rvalid_o  (lsu_rvalid_o),
    .lsu_rdata_o   (lsu_rdata_o),
    .port_req_o    (port_req_o),
    .port_addr_o   (port_addr_o),
    .port_be_o     (port_be_o),
    .port_gnt_i    (port_gnt_i),
    .port_rvalid_i (port_rvalid_i),
    .port_rdata_i  (port_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    z_pattern = 10'b10_0001_0000;

    // ---- reset: outputs low even with requests and a response present
    rst_i = 1'b1;
    zcmt_req_i = 1'b1; zcmt_addr_i = 32'h0000_1040;
    lsu_req_i = 1'b1;  lsu_addr_i = 32'h0000_2000; lsu_be_i = 4'hF;
    port_gnt_i = 1'b1; port_rvalid_i = 1'b1; port_rdata_i = 32'h1234_5678;
    #2;
    check("rst_port_req", {31'd0, port_req_o}, 32'd0);
    check("rst_gnts", {30'd0, zcmt_gnt_o, lsu_gnt_o}, 32'd0);
    check("rst_rvalids", {30'd0, zcmt_rvalid_o, lsu_rvalid_o}, 32'd0);
    check("rst_addr", port_addr_o, 32'd0);
    next_cycle();
    rst_i = 1'b0; zcmt_req_i = 1'b0; lsu_req_i = 1'b0;
    port_gnt_i = 1'b0; port_rvalid_i = 1'b0;

    // ---- single ZCMT fetch, grant one cycle later
    next_cycle();
    zcmt_req_i = 1'b1; zcmt_addr_i = 32'h0000_1040;
    #1;
    check("z1_req", {31'd0, port_req_o}, 32'd1);
    check("z1_addr", port_addr_o, 32'h0000_1040);
    check("z1_nogrant", {31'd0, zcmt_gnt_o}, 32'd0);
    next_cycle();
    port_gnt_i = 1'b1;
    #1;
    check("z1_gnt", {30'd0, zcmt_gnt_o, lsu_gnt_o}, 32'b10);
    next_cycle();
    zcmt_req_i = 1'b0; port_gnt_i = 1'b0;
    port_rvalid_i = 1'b1; port_rdata_i = 32'h8000_0100;
    #1;
    check("z1_gnt_once", {31'd0, zcmt_gnt_o}, 32'd0);
    check("z1_rvalid", {30'd0, zcmt_rvalid_o, lsu_rvalid_o}, 32'b10);
    check("z1_rdata", zcmt_rdata_o, 32'h8000_0100);
    next_cycle();
    port_rvalid_i = 1'b0;

    // ---- both requesting, grant every cycle, previous grant answered each cycle
    zcmt_addr_i = 32'h0000_1040; lsu_addr_i = 32'h0000_2000;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      zcmt_req_i = 1'b1; lsu_req_i = 1'b1; port_gnt_i = 1'b1;
      port_rvalid_i = (i != 0);
      #1;
      check($sformatf("seq_gnt%0d", i), {30'd0, zcmt_gnt_o, lsu_gnt_o},
            {30'd0, z_pattern[i], ~z_pattern[i]});
      if (i > 0)
        check($sformatf("seq_rsp%0d", i), {30'd0, zcmt_rvalid_o, lsu_rvalid_o},
              {30'd0, z_pattern[i-1], ~z_pattern[i-1]});
    end
    next_cycle();
    zcmt_req_i = 1'b0; lsu_req_i = 1'b0; port_gnt_i = 1'b0; port_rvalid_i = 1'b1;
    #1;
    check("seq_drain", {30'd0, zcmt_rvalid_o, lsu_rvalid_o}, 32'b10);
    next_cycle();
    port_rvalid_i = 1'b0;

    // ---- LSU then ZCMT grant; responses come back in order
    lsu_req_i = 1'b1; lsu_addr_i = 32'h0000_2004; port_gnt_i = 1'b1;
    #1;
    check("ord_lsu_gnt", {30'd0, zcmt_gnt_o, lsu_gnt_o}, 32'b01);
    next_cycle();
    lsu_req_i = 1'b0; zcmt_req_i = 1'b1; zcmt_addr_i = 32'h0000_1044;
    #1;
    check("ord_z_gnt", {30'd0, zcmt_gnt_o, lsu_gnt_o}, 32'b10);
    check("ord_z_be", {28'd0, port_be_o}, 32'hF);
    next_cycle();
    zcmt_req_i = 1'b0; port_gnt_i = 1'b0; port_rvalid_i = 1'b1; port_rdata_i = 32'hA;
    #1;
    check("ord_rsp_a", {30'd0, zcmt_rvalid_o, lsu_rvalid_o}, 32'b01);
    check("ord_rdata_a", lsu_rdata_o, 32'hA);
    next_cycle();
    port_rdata_i = 32'hB;
    #1;
    check("ord_rsp_b", {30'd0, zcmt_rvalid_o, lsu_rvalid_o}, 32'b10);
    check("ord_rdata_b", zcmt_rdata_o, 32'hB);
    next_cycle();
    port_rvalid_i = 1'b0;

    // ---- outstanding limit: third request held back until a response
    lsu_req_i = 1'b1; lsu_addr_i = 32'h0000_3000; lsu_be_i = 4'hF; port_gnt_i = 1'b1;
    #1;
    check("lim_g1", {31'd0, lsu_gnt_o}, 32'd1);
    next_cycle();
    #1;
    check("lim_g2", {31'd0, lsu_gnt_o}, 32'd1);
    next_cycle();
    #1;
    check("lim_full_req", {31'd0, port_req_o}, 32'd0);
    check("lim_full_gnt", {31'd0, lsu_gnt_o}, 32'd0);
    next_cycle();
    port_rvalid_i = 1'b1; port_rdata_i = 32'h31;
    #1;
    check("lim_pop_req", {31'd0, port_req_o}, 32'd0);
    check("lim_pop_rsp", {31'd0, lsu_rvalid_o}, 32'd1);
    next_cycle();
    port_rvalid_i = 1'b0;
    #1;
    check("lim_g3", {31'd0, lsu_gnt_o}, 32'd1);
    check("lim_g3_addr", port_addr_o, 32'h0000_3000);
    next_cycle();
    lsu_req_i = 1'b0; port_gnt_i = 1'b0; port_rvalid_i = 1'b1;
    next_cycle();
    next_cycle();
    port_rvalid_i = 1'b0;

    // ---- stalled LSU owner keeps the port while ZCMT waits
    lsu_req_i = 1'b1; lsu_addr_i = 32'h0000_4000; lsu_be_i = 4'h3;
    #1;
    check("hold_req", {31'd0, port_req_o}, 32'd1);
    check("hold_addr0", port_addr_o, 32'h0000_4000);
    for (int k = 1; k < 5; k++) begin
      next_cycle();
      zcmt_req_i = 1'b1; zcmt_addr_i = 32'h0000_1048;
      #1;
      check($sformatf("hold_addr%0d", k), port_addr_o, 32'h0000_4000);
      check($sformatf("hold_be%0d", k), {28'd0, port_be_o}, 32'h3);
      check($sformatf("hold_zgnt%0d", k), {31'd0, zcmt_gnt_o}, 32'd0);
    end
    next_cycle();
    port_gnt_i = 1'b1;
    #1;
    check("hold_lsu_gnt", {30'd0, zcmt_gnt_o, lsu_gnt_o}, 32'b01);
    next_cycle();
    lsu_req_i = 1'b0;
    #1;
    check("hold_z_gnt", {30'd0, zcmt_gnt_o, lsu_gnt_o}, 32'b10);
    check("hold_z_addr", port_addr_o, 32'h0000_1048);

    // ---- reset with two outstanding; stale responses afterwards are dropped
    next_cycle();
    zcmt_req_i = 1'b0; lsu_req_i = 1'b1; lsu_addr_i = 32'h0000_5000;
    port_rvalid_i = 1'b1; port_rdata_i = 32'h77;
    #1;
    check("prerst_rsp", {30'd0, zcmt_rvalid_o, lsu_rvalid_o}, 32'b01);
    rst_i = 1'b1;
    #1;
    check("rst2_rsp", {30'd0, zcmt_rvalid_o, lsu_rvalid_o}, 32'd0);
    check("rst2_req", {31'd0, port_req_o}, 32'd0);
    check("rst2_gnt", {30'd0, zcmt_gnt_o, lsu_gnt_o}, 32'd0);
    check("rst2_rdata", lsu_rdata_o, 32'd0);
    next_cycle();
    next_cycle();
    rst_i = 1'b0; lsu_req_i = 1'b0; port_gnt_i = 1'b0; port_rdata_i = 32'hDEAD;
    #1;
    check("stale1", {30'd0, zcmt_rvalid_o, lsu_rvalid_o}, 32'd0);
    next_cycle();
    #1;
    check("stale2", {30'd0, zcmt_rvalid_o, lsu_rvalid_o}, 32'd0);
    next_cycle();
    port_rvalid_i = 1'b0; zcmt_req_i = 1'b1; zcmt_addr_i = 32'h0000_1050; port_gnt_i = 1'b1;
    #1;
    check("post_z_gnt", {30'd0, zcmt_gnt_o, lsu_gnt_o}, 32'b10);
    next_cycle();
    zcmt_req_i = 1'b0; port_gnt_i = 1'b0; port_rvalid_i = 1'b1; port_rdata_i = 32'h8000_0104;
    #1;
    check("post_z_rsp", {30'd0, zcmt_rvalid_o, lsu_rvalid_o}, 32'b10);
    check("post_z_rdata", zcmt_rdata_o, 32'h8000_0104);
    next_cycle();
    port_rvalid_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/zcmt_lsu_port_arbiter.md
ZCMT_LSU_PORT_ARBITER -- requirements
Module: zcmt_lsu_port_arbiter

Interface
REQ-001 Parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, core configuration (XLEN used).
REQ-002 Parameter STARVE_LIMIT, default 4, max consecutive load-unit grants while ZCMT waits.
REQ-003 Parameter MAX_OUTSTANDING, default 2, max in-flight requests on the shared port.
REQ-004 clk_i  in  1  single clock; all logic rising-edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 zcmt_req_i  in  1  ZCMT table-entry fetch request.
REQ-007 zcmt_addr_i  in  XLEN  table-entry address (word aligned).
REQ-008 zcmt_gnt_o  out  1  ZCMT request accepted this cycle.
REQ-009 zcmt_rvalid_o / zcmt_rdata_o  out  1 / XLEN  ZCMT response.
REQ-010 lsu_req_i / lsu_addr_i / lsu_be_i  in  1 / XLEN / XLEN/8  load-unit request.
REQ-011 lsu_gnt_o / lsu_rvalid_o / lsu_rdata_o  out  1 / 1 / XLEN  load-unit grant and response.
REQ-012 port_req_o / port_addr_o / port_be_o  out  1 / XLEN / XLEN/8  shared dcache request.
REQ-013 port_gnt_i  in  1  dcache accepted request.
REQ-014 port_rvalid_i / port_rdata_i  in  1 / XLEN  dcache response, in request order.

Function
REQ-015 Owner FSM states: IDLE, BUSY_ZCMT, BUSY_LSU; port_req_o=0 in IDLE.
REQ-016 IDLE with any request and outstanding count < MAX_OUTSTANDING -> select winner, drive port same cycle (combinational pass-through), enter BUSY_<winner> if port_gnt_i=0.
REQ-017 BUSY_x: owner's addr/be held on port until port_gnt_i; no owner switch before grant.
REQ-018 Grant routing: zcmt_gnt_o / lsu_gnt_o = port_gnt_i AND owner/winner match; on grant -> IDLE.
REQ-019 Priority: LSU wins by default; ZCMT wins when starve counter = STARVE_LIMIT or LSU idle.
REQ-020 Starve counter (clog2(STARVE_LIMIT+1) bits): +1 per LSU grant while zcmt_req_i=1, saturating; cleared on ZCMT grant or zcmt_req_i=0.
REQ-021 Owner FIFO (depth MAX_OUTSTANDING, 1 bit: 1=ZCMT) pushed on every grant, popped on port_rvalid_i.
REQ-022 Response routing: port_rvalid_i steered to head owner's rvalid; rdata forwarded to both, rvalid only to owner.
REQ-023 FIFO full -> port_req_o=0, both gnt=0 until a response pops.
REQ-024 Simultaneous grant and response in one cycle: push and pop both occur; count unchanged.
REQ-025 port_rvalid_i with FIFO empty: dropped, no rvalid output, sticky assertion failure in simulation.
REQ-026 Requester dropping req while in BUSY_x is illegal (protocol assertion); RTL returns to IDLE.

Reset
REQ-027 rst_i asserted at any time: FSM=IDLE, FIFO empty, starve counter 0, all outputs 0 asynchronously; in-flight responses after reset ignored.

Structure
REQ-028 Owner encoding, FSM state enum, and STARVE_LIMIT default in shared package ariane_pkg.
REQ-029 One sub-module: owner FIFO as existing fifo_v3 instance (DATA_WIDTH 1, DEPTH MAX_OUTSTANDING).

Verification
REQ-030 Only ZCMT req addr 0x0000_1040, gnt next cycle, rdata 0x8000_0100 -> zcmt_gnt_o 1 cycle, zcmt_rvalid_o with 0x8000_0100, lsu_rvalid_o stays 0.
REQ-031 Both requesting continuously, gnt every cycle -> grant sequence L,L,L,L,Z,L,L,L,L,Z.
REQ-032 LSU grant, then ZCMT grant, responses 0xA, 0xB -> lsu gets 0xA, zcmt gets 0xB, in order.
REQ-033 Three grants without responses (MAX_OUTSTANDING=2) -> third request not driven until first rvalid; then granted.
REQ-034 port_gnt_i held 0 for 5 cycles with LSU owner while ZCMT raises req -> port_addr_o stays LSU address, no switch.
REQ-035 rst_i pulsed with 2 outstanding -> outputs 0 immediately; subsequent stale port_rvalid_i produces no requester rvalid.
